// File: rtl/fwd_pkg.sv
// Shared constants and flat-vector slicing helper for the operand-forwarding stage.
package fwd_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN_DEF = 32;
  // Upper bound on forwarding sources supported by the slicing helper.
  localparam int unsigned MAX_SRC  = 8;

  function automatic logic [REG_AW-1:0] src_rd(input logic [REG_AW*MAX_SRC-1:0] rd_flat,
                                               input int unsigned idx);
    return rd_flat[idx*REG_AW +: REG_AW];
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority scan of one source operand across the in-flight forwarding sources.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NSRC = 3
) (
  input  logic [REG_AW-1:0]    addr,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [NSRC-1:0]      fwd_valid,
  input  logic [REG_AW*NSRC-1:0] fwd_rd,
  input  logic [XLEN*NSRC-1:0] fwd_data,
  input  logic [NSRC-1:0]      fwd_pend,
  output logic [XLEN-1:0]      data,
  output logic                 hit,
  output logic                 pend
);

  logic [REG_AW*MAX_SRC-1:0] rd_flat;

  always_comb begin
    rd_flat = '0;
    rd_flat[REG_AW*NSRC-1:0] = fwd_rd;
  end

  // Index 0 is youngest; the first match stops the scan so younger always wins.
  always_comb begin
    data = rf_data;
    hit  = 1'b0;
    pend = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!hit && fwd_valid[i] && (src_rd(rd_flat, i) == addr) && (addr != '0)) begin
        hit  = 1'b1;
        data = fwd_data[i*XLEN +: XLEN];
        pend = fwd_pend[i];
      end
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID/EX operand forwarding, load-use stall and pipeline register with flush bubbles.
// Optional FWD_STATS_EN adds saturating stall_cnt / hit_cnt counters.
module fwd_operand_stage
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned NSRC       = 3,
  parameter int unsigned BUBBLE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [REG_AW-1:0]      rs1_addr,
  input  logic [REG_AW-1:0]      rs2_addr,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        imm,
  input  logic                   sel_pc,
  input  logic                   sel_imm,
  input  logic [NSRC-1:0]        fwd_valid,
  input  logic [REG_AW*NSRC-1:0] fwd_rd,
  input  logic [XLEN*NSRC-1:0]   fwd_data,
  input  logic [NSRC-1:0]        fwd_pend,
  input  logic                   flush,
  input  logic                   stall_in,
  output logic                   stall_out,
  output logic                   out_valid,
  output logic [XLEN-1:0]        op_a,
  output logic [XLEN-1:0]        op_b,
  output logic [XLEN-1:0]        alu_x,
  output logic [XLEN-1:0]        alu_y,
  output logic                   fwd_hit_a,
  output logic                   fwd_hit_b
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            hit_cnt
`endif
);

  logic [XLEN-1:0] data_a, data_b;
  logic            hit_a, hit_b, pend_a, pend_b;
  logic            haz;
  logic [2:0]      bcnt;
  logic [XLEN-1:0] pc_q, imm_q;
  logic            sel_pc_q, sel_imm_q;

  fwd_select #(
    .XLEN (XLEN),
    .NSRC (NSRC)
  ) u_sel_a (
    .addr      (rs1_addr),
    .rf_data   (rs1_data),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .fwd_pend  (fwd_pend),
    .data      (data_a),
    .hit       (hit_a),
    .pend      (pend_a)
  );

  fwd_select #(
    .XLEN (XLEN),
    .NSRC (NSRC)
  ) u_sel_b (
    .addr      (rs2_addr),
    .rf_data   (rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .fwd_pend  (fwd_pend),
    .data      (data_b),
    .hit       (hit_b),
    .pend      (pend_b)
  );

  // Only the winning source's pend matters; a shadowed older load is irrelevant.
  assign haz       = in_valid & ((hit_a & pend_a) | (hit_b & pend_b));
  assign stall_out = (haz & ~flush & (bcnt == 3'd0)) | stall_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      sel_pc_q  <= 1'b0;
      sel_imm_q <= 1'b0;
      fwd_hit_a <= 1'b0;
      fwd_hit_b <= 1'b0;
      bcnt      <= 3'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      fwd_hit_a <= 1'b0;
      fwd_hit_b <= 1'b0;
      bcnt      <= 3'(BUBBLE_CYC);
    end else if (stall_in) begin
      // hold everything
    end else if ((bcnt != 3'd0) || haz) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      fwd_hit_a <= 1'b0;
      fwd_hit_b <= 1'b0;
      if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
    end else begin
      out_valid <= in_valid;
      op_a      <= data_a;
      op_b      <= data_b;
      pc_q      <= pc;
      imm_q     <= imm;
      sel_pc_q  <= sel_pc;
      sel_imm_q <= sel_imm;
      fwd_hit_a <= hit_a;
      fwd_hit_b <= hit_b;
    end
  end

  assign alu_x = sel_pc_q  ? pc_q  : op_a;
  assign alu_y = sel_imm_q ? imm_q : op_b;

`ifdef FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      hit_cnt   <= '0;
    end else if (!flush && !stall_in) begin
      if (bcnt == 3'd0 && haz && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bcnt == 3'd0 && !haz && in_valid && (hit_a | hit_b) && hit_cnt != '1) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed self-checking bench for fwd_operand_stage (NSRC=3, XLEN=32, BUBBLE_CYC=1).
module tb_fwd_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, pc, imm;
  logic        sel_pc, sel_imm;
  logic [2:0]  fwd_valid, fwd_pend;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic        flush, stall_in, stall_out, out_valid, fwd_hit_a, fwd_hit_b;
  logic [31:0] op_a, op_b, alu_x, alu_y;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt, hit_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fwd_operand_stage #(
    .XLEN       (32),
    .NSRC       (3),
    .BUBBLE_CYC (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .pc        (pc),
    .imm       (imm),
    .sel_pc    (sel_pc),
    .sel_imm   (sel_imm),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .fwd_pend  (fwd_pend),
    .flush     (flush),
    .stall_in  (stall_in),
    .stall_out (stall_out),
    .out_valid (out_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .fwd_hit_a (fwd_hit_a),
    .fwd_hit_b (fwd_hit_b)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .hit_cnt   (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
    pc = 0; imm = 0; sel_pc = 0; sel_imm = 0; fwd_valid = 0; fwd_pend = 0;
    fwd_rd = 0; fwd_data = 0; flush = 0; stall_in = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; in_valid = 1; rs1_addr = 5'($urandom); rs2_addr = 5'($urandom);
    rs1_data = $urandom; rs2_data = $urandom; pc = $urandom; imm = $urandom;
    sel_pc = 1'($urandom); sel_imm = 1'($urandom); fwd_valid = 3'($urandom);
    fwd_rd = 15'($urandom); fwd_data = {$urandom, $urandom, $urandom};
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall_out0 got=%b exp=0", stall_out);
    end
    stall_in = 1; #1;
    n_checks++;
    if (stall_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall_out1 got=%b exp=1", stall_out);
    end
    step(); step();
    n_checks++;
    if ({out_valid, fwd_hit_a, fwd_hit_b} !== 3'b000 || op_a !== 0 || op_b !== 0) begin
      n_fail++;
      $display("FAIL reset_regs got v=%b ha=%b hb=%b a=%h b=%h exp all 0",
               out_valid, fwd_hit_a, fwd_hit_b, op_a, op_b);
    end
    n_checks++;
    if (alu_x !== 0 || alu_y !== 0) begin
      n_fail++; $display("FAIL reset_alu got x=%h y=%h exp 0", alu_x, alu_y);
    end
    idle();
  endtask

  task automatic test_priority();
    idle();
    in_valid = 1; rs1_addr = 5; rs1_data = 32'hAAAA;
    fwd_valid = 3'b101; fwd_rd = {5'd5, 5'd0, 5'd5};
    fwd_data = {32'h33, 32'h22, 32'h11};
    step();
    n_checks++;
    if (op_a !== 32'h11 || fwd_hit_a !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL prio_young got a=%h hit=%b v=%b exp a=11 hit=1 v=1",
                         op_a, fwd_hit_a, out_valid);
    end
    fwd_valid = 3'b100;
    step();
    n_checks++;
    if (op_a !== 32'h33 || fwd_hit_a !== 1'b1) begin
      n_fail++; $display("FAIL prio_old got a=%h hit=%b exp a=33 hit=1", op_a, fwd_hit_a);
    end
    fwd_valid = 3'b000;
    step();
    n_checks++;
    if (op_a !== 32'hAAAA || fwd_hit_a !== 1'b0) begin
      n_fail++; $display("FAIL prio_rf got a=%h hit=%b exp a=aaaa hit=0", op_a, fwd_hit_a);
    end
  endtask

  task automatic test_x0();
    idle();
    in_valid = 1; rs2_addr = 0; rs2_data = 0;
    fwd_valid = 3'b001; fwd_rd = 15'd0; fwd_data = {64'h0, 32'hFF};
    step();
    n_checks++;
    if (op_b !== 32'h0 || fwd_hit_b !== 1'b0) begin
      n_fail++; $display("FAIL x0_b got b=%h hit=%b exp b=0 hit=0", op_b, fwd_hit_b);
    end
  endtask

  task automatic test_load_use();
    idle();
    in_valid = 1; rs1_addr = 7; rs1_data = 32'h1;
    fwd_valid = 3'b001; fwd_rd = {10'd0, 5'd7}; fwd_pend = 3'b001;
    #1;
    n_checks++;
    if (stall_out !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall got=%b exp=1", stall_out);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || op_a !== 0) begin
      n_fail++; $display("FAIL lu_bubble got v=%b a=%h exp v=0 a=0", out_valid, op_a);
    end
    fwd_pend = 3'b000; fwd_data = {64'h0, 32'hAB};
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL lu_release got=%b exp=0", stall_out);
    end
    step();
    n_checks++;
    if (op_a !== 32'hAB || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL lu_data got a=%h v=%b exp a=ab v=1", op_a, out_valid);
    end
    // Pending src1 shadowed by non-pending src0 match.
    fwd_valid = 3'b011; fwd_rd = {5'd0, 5'd7, 5'd7}; fwd_pend = 3'b010;
    fwd_data = {32'h0, 32'h99, 32'h77};
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL lu_shadow_stall got=%b exp=0", stall_out);
    end
    step();
    n_checks++;
    if (op_a !== 32'h77 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL lu_shadow_data got a=%h v=%b exp a=77 v=1", op_a, out_valid);
    end
  endtask

  task automatic test_stall_hold();
    idle();
    in_valid = 1; rs1_addr = 3; rs1_data = 32'h1234;
    step();
    stall_in = 1; rs1_data = 32'h5678;
    step();
    n_checks++;
    if (op_a !== 32'h1234 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL hold got a=%h v=%b exp a=1234 v=1", op_a, out_valid);
    end
    stall_in = 0;
    step();
    n_checks++;
    if (op_a !== 32'h5678) begin
      n_fail++; $display("FAIL hold_release got a=%h exp 5678", op_a);
    end
  endtask

  task automatic test_flush();
    idle();
    // Flush with a live hazard: flush masks the stall, then bcnt masks it.
    in_valid = 1; rs1_addr = 7; fwd_valid = 3'b001; fwd_rd = {10'd0, 5'd7};
    fwd_pend = 3'b001; fwd_data = {64'h0, 32'h42}; flush = 1;
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_mask got=%b exp=0", stall_out);
    end
    step();
    flush = 0; #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL bcnt_mask got=%b exp=0", stall_out);
    end
    step();
    n_checks++;
    if (stall_out !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_bubble got stall=%b v=%b exp 1 0", stall_out, out_valid);
    end
    fwd_pend = 0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || op_a !== 32'h42) begin
      n_fail++; $display("FAIL flush_resume got v=%b a=%h exp 1 42", out_valid, op_a);
    end
    // Flush overrides stall_in; exactly 2 bubbles follow.
    flush = 1; stall_in = 1;
    step();
    flush = 0; stall_in = 0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_b1 got v=%b exp 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_b2 got v=%b exp 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_b3 got v=%b exp 1", out_valid);
    end
    // Reset while bcnt == 1 clears the counter.
    flush = 1;
    step();
    flush = 0; rst = 1;
    step();
    rst = 0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || op_a !== 32'h42) begin
      n_fail++; $display("FAIL rst_bcnt got v=%b a=%h exp 1 42", out_valid, op_a);
    end
  endtask

  task automatic test_alu_mux();
    logic [31:0] ex, ey;
    idle();
    in_valid = 1; rs1_addr = 3; rs1_data = 32'h10; rs2_addr = 4; rs2_data = 32'h20;
    pc = 32'h400; imm = 32'h8;
    for (int k = 0; k < 4; k++) begin
      sel_pc = k[0]; sel_imm = k[1];
      ex = k[0] ? 32'h400 : 32'h10;
      ey = k[1] ? 32'h8 : 32'h20;
      step();
      n_checks++;
      if (alu_x !== ex || alu_y !== ey) begin
        n_fail++; $display("FAIL alu_mux%0d got x=%h y=%h exp x=%h y=%h",
                           k, alu_x, alu_y, ex, ey);
      end
    end
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats();
    idle();
    rst = 1;
    step();
    rst = 0; in_valid = 1; rs1_addr = 7; fwd_valid = 3'b001; fwd_rd = {10'd0, 5'd7};
    fwd_pend = 3'b001;
    step(); step(); step();
    n_checks++;
    if (stall_cnt !== 32'd3) begin
      n_fail++; $display("FAIL stats_stall got=%0d exp=3", stall_cnt);
    end
    fwd_pend = 0;
    step();
    n_checks++;
    if (hit_cnt !== 32'd1) begin
      n_fail++; $display("FAIL stats_hit got=%0d exp=1", hit_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_priority();
    test_x0();
    test_load_use();
    test_stall_hold();
    test_flush();
    test_alu_mux();
`ifdef FWD_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
